mod_updown_counter: RTL and testbench

Parametrised synchronous modulo up/down counter that generalises the team's fixed 4-bit T-flip-flop ripple counter. It adds configurable width and modulus, direction control, count enable, synchronous clear and load, wrap or saturate at the limits, and a cascade-ready terminal-count output. It is the common counting primitive for timers, prescalers and address generators in the lab designs.

---
 rtl/cnt_pkg.sv | 31 +++
 rtl/mod_updown_counter.sv | 93 +++++++++
 tb/tb_mod_updown_counter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared counting arithmetic for modulo up/down counters, prescalers and timers.
// Values are carried in CNT_MAX_W+1 bits so a modulus of 2^WIDTH never truncates.
package cnt_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam int   CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W:0] cnt_val_t;

  // Next count value for one enabled step; saturate holds at the limit instead of wrapping.
  function automatic cnt_val_t cnt_next(input cnt_val_t q, input logic up,
                                        input cnt_val_t modulus, input logic saturate);
    cnt_val_t nxt;
    nxt = q;
    if (up == CNT_UP) begin
      if (q == modulus - 1'b1) nxt = saturate ? q : '0;
      else                     nxt = q + 1'b1;
    end else begin
      if (q == '0) nxt = saturate ? q : modulus - 1'b1;
      else         nxt = q - 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic cnt_at_limit(input cnt_val_t q, input logic up,
                                        input cnt_val_t modulus);
    return (up == CNT_UP) ? (q == modulus - 1'b1) : (q == '0);
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with clear/load, wrap or saturate,
// overflow pulse/sticky flag and a combinational terminal count for cascading.
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             load_err
);
  import cnt_pkg::*;

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("mod_updown_counter: WIDTH=%0d out of range", WIDTH);
  end
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("mod_updown_counter: RESET_VAL=%0d not below MODULUS", RESET_VAL);
  end

  localparam cnt_val_t         MOD_V = cnt_val_t'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_sticky;
  logic             r_load_err;

  cnt_val_t         w_q_ext;
  cnt_val_t         w_nxt_full;
  logic [WIDTH-1:0] w_nxt;
  logic             w_at_lim;
  logic             w_load_bad;
  logic             w_unused_hi;

  assign w_q_ext     = cnt_val_t'(r_q);
  assign w_nxt_full  = cnt_next(w_q_ext, up, MOD_V, SATURATE != 0);
  assign w_nxt       = w_nxt_full[WIDTH-1:0];
  assign w_unused_hi = |w_nxt_full[CNT_MAX_W:WIDTH];
  assign w_at_lim    = cnt_at_limit(w_q_ext, up, MOD_V);
  assign w_load_bad  = cnt_val_t'(load_val) >= MOD_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= RST_Q;
      r_ovf      <= 1'b0;
      r_sticky   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_q      <= RST_Q;
        r_sticky <= 1'b0;
      end else if (load) begin
        // Out-of-range loads clamp to the top of the range and flag it.
        if (w_load_bad) begin
          r_q        <= MAX_Q;
          r_load_err <= 1'b1;
        end else begin
          r_q <= load_val;
        end
      end else if (en) begin
        r_q <= w_nxt;
        if (w_at_lim) begin
          r_ovf    <= 1'b1;
          r_sticky <= 1'b1;
        end
      end
    end
  end

  assign q          = r_q;
  assign tc         = en & w_at_lim;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: expected results are queued as stimulus is driven and
// popped after the following clock edge.
module tb_mod_updown_counter;

  typedef struct {
    logic [7:0] q;
    logic       ovf;
    logic       sticky;
    logic       lerr;
  } exp_t;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       up;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // wrap instance, MODULUS=10
  logic       w_clr, w_load, w_en, w_up;
  logic [3:0] w_lv, w_q;
  logic       w_tc, w_ovf, w_sticky, w_lerr;
  // saturating instance, MODULUS=10
  logic       s_clr, s_load, s_en, s_up;
  logic [3:0] s_lv, s_q;
  logic       s_tc, s_ovf, s_sticky, s_lerr;
  // cascaded pair, MODULUS=16
  logic       c_clr, c_en;
  logic [3:0] c_lv, lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_ovf, hi_ovf, lo_st, hi_st, lo_le, hi_le;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load), .load_val(w_lv), .en(w_en),
    .up(w_up), .q(w_q), .tc(w_tc), .ovf(w_ovf), .ovf_sticky(w_sticky), .load_err(w_lerr));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .load(s_load), .load_val(s_lv), .en(s_en),
    .up(s_up), .q(s_q), .tc(s_tc), .ovf(s_ovf), .ovf_sticky(s_sticky), .load_err(s_lerr));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(1'b0), .load_val(c_lv), .en(c_en),
    .up(1'b1), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf), .ovf_sticky(lo_st), .load_err(lo_le));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(1'b0), .load_val(c_lv), .en(lo_tc),
    .up(1'b1), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf), .ovf_sticky(hi_st), .load_err(hi_le));

  function automatic exp_t mk(input int q, input logic ovf, input logic st, input logic le);
    exp_t e;
    e.q = 8'(q); e.ovf = ovf; e.sticky = st; e.lerr = le;
    return e;
  endfunction

  // Drive one cycle of stimulus on the wrap instance and queue its expected result.
  task automatic drive_w(input stim_t s, input exp_t e);
    w_clr = s.clr; w_load = s.load; w_lv = s.lv; w_en = s.en; w_up = s.up;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    w_clr = 0; w_load = 0; w_lv = 0; w_en = 0; w_up = 1;
    s_clr = 0; s_load = 0; s_lv = 0; s_en = 0; s_up = 1;
    c_clr = 0; c_en = 0; c_lv = 0;
    #12;
    checks++;
    if (w_q !== 4'd0 || w_ovf !== 1'b0 || w_sticky !== 1'b0 || w_lerr !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap: got q=%0d ovf=%b st=%b le=%b, expected 0 0 0 0", w_q, w_ovf, w_sticky, w_lerr);
    end
    checks++;
    if (s_q !== 4'd0 || s_ovf !== 1'b0 || s_sticky !== 1'b0 || s_lerr !== 1'b0) begin
      failures++;
      $display("FAIL reset_sat: got q=%0d ovf=%b st=%b le=%b, expected 0 0 0 0", s_q, s_ovf, s_sticky, s_lerr);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    @(negedge clk); w_en = 1; w_up = 1;
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (w_tc !== ((k - 1) % 10 == 9)) begin
        failures++;
        $display("FAIL wrap_up_tc k=%0d: got %b expected %b", k, w_tc, ((k - 1) % 10 == 9));
      end
      sb.push_back(mk(k % 10, k == 10, k >= 10, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (w_q !== e.q[3:0] || w_ovf !== e.ovf || w_sticky !== e.sticky || w_lerr !== e.lerr) begin
        failures++;
        $display("FAIL wrap_up k=%0d: got q=%0d ovf=%b st=%b le=%b, expected q=%0d ovf=%b st=%b le=%b",
                 k, w_q, w_ovf, w_sticky, w_lerr, e.q, e.ovf, e.sticky, e.lerr);
      end
      @(negedge clk);
    end
    w_en = 0;
  endtask

  task automatic test_wrap_down();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = '{1, 0, 0, 0, 1}; ex[0] = mk(0, 0, 0, 0);
    st[1] = '{0, 0, 0, 1, 0}; ex[1] = mk(9, 1, 1, 0);
    st[2] = '{0, 0, 0, 1, 0}; ex[2] = mk(8, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_w(st[i], ex[i]);
      if (i == 1) begin
        #1; checks++;
        if (w_tc !== 1'b1) begin
          failures++; $display("FAIL down_tc_at_zero: got %b expected 1", w_tc);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (w_q !== e.q[3:0] || w_ovf !== e.ovf || w_sticky !== e.sticky || w_lerr !== e.lerr) begin
        failures++;
        $display("FAIL wrap_down i=%0d: got q=%0d ovf=%b st=%b le=%b, expected q=%0d ovf=%b st=%b le=%b",
                 i, w_q, w_ovf, w_sticky, w_lerr, e.q, e.ovf, e.sticky, e.lerr);
      end
    end
    @(negedge clk); w_en = 0;
  endtask

  task automatic test_saturate();
    exp_t e;
    @(negedge clk); s_load = 1; s_lv = 4'd9; s_en = 0; s_up = 1;
    sb.push_back(mk(9, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (s_q !== e.q[3:0] || s_ovf !== e.ovf || s_sticky !== e.sticky || s_lerr !== e.lerr) begin
        failures++;
        $display("FAIL saturate k=%0d: got q=%0d ovf=%b st=%b le=%b, expected q=%0d ovf=%b st=%b le=%b",
                 k, s_q, s_ovf, s_sticky, s_lerr, e.q, e.ovf, e.sticky, e.lerr);
      end
      @(negedge clk);
      s_load = 0; s_en = (k < 3);
      if (k < 3) begin
        #1; checks++;
        if (s_tc !== 1'b1) begin
          failures++; $display("FAIL sat_tc k=%0d: got %b expected 1", k, s_tc);
        end
      end
      sb.push_back(mk(9, k < 3, 1, 0));
    end
    void'(sb.pop_front());
    s_en = 0;
  endtask

  task automatic test_load_err();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = '{0, 1, 4'd12, 0, 1}; ex[0] = mk(9, 0, 1, 1);
    st[1] = '{0, 0, 4'd0,  0, 1}; ex[1] = mk(9, 0, 1, 0);
    st[2] = '{0, 1, 4'd3,  1, 1}; ex[2] = mk(3, 0, 1, 0);
    st[3] = '{0, 0, 4'd0,  0, 1}; ex[3] = mk(3, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_w(st[i], ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (w_q !== e.q[3:0] || w_ovf !== e.ovf || w_sticky !== e.sticky || w_lerr !== e.lerr) begin
        failures++;
        $display("FAIL load_err i=%0d: got q=%0d ovf=%b st=%b le=%b, expected q=%0d ovf=%b st=%b le=%b",
                 i, w_q, w_ovf, w_sticky, w_lerr, e.q, e.ovf, e.sticky, e.lerr);
      end
    end
  endtask

  task automatic test_clr_priority();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = '{0, 1, 4'd5,  0, 1}; ex[0] = mk(5, 0, 1, 0);
    st[1] = '{1, 1, 4'd12, 1, 1}; ex[1] = mk(0, 0, 0, 0);
    st[2] = '{0, 0, 4'd0,  0, 1}; ex[2] = mk(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_w(st[i], ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (w_q !== e.q[3:0] || w_ovf !== e.ovf || w_sticky !== e.sticky || w_lerr !== e.lerr) begin
        failures++;
        $display("FAIL clr_priority i=%0d: got q=%0d ovf=%b st=%b le=%b, expected q=%0d ovf=%b st=%b le=%b",
                 i, w_q, w_ovf, w_sticky, w_lerr, e.q, e.ovf, e.sticky, e.lerr);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); w_clr = 0; w_load = 0; w_en = 1; w_up = 1;
    repeat (6) @(posedge clk);
    #1; checks++;
    if (w_q !== 4'd6) begin
      failures++; $display("FAIL async_pre: got q=%0d expected 6", w_q);
    end
    #1 rst_n = 1'b0;
    #1; checks++;
    if (w_q !== 4'd0 || w_sticky !== 1'b0 || w_ovf !== 1'b0) begin
      failures++; $display("FAIL async_now: got q=%0d st=%b ovf=%b expected 0 0 0", w_q, w_sticky, w_ovf);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1; checks++;
    if (w_q !== 4'd1) begin
      failures++; $display("FAIL async_first_edge: got q=%0d expected 1", w_q);
    end
    @(negedge clk); w_en = 0;
  endtask

  task automatic test_cascade();
    exp_t e;
    @(negedge clk); c_clr = 1;
    @(posedge clk); #1;
    checks++;
    if ({hi_q, lo_q} !== 8'h00) begin
      failures++; $display("FAIL cascade_clr: got %h expected 00", {hi_q, lo_q});
    end
    @(negedge clk); c_clr = 0; c_en = 1;
    for (int k = 1; k <= 257; k++) begin
      sb.push_back(mk(k % 256, 0, 0, 0));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({hi_q, lo_q} !== e.q) begin
        failures++; $display("FAIL cascade k=%0d: got %h expected %h", k, {hi_q, lo_q}, e.q);
      end
    end
    @(negedge clk); c_en = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_err();
    test_clr_priority();
    test_async_reset();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
